run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Run controller directly upstream of the 9-bit processor top level. Drives its active-high `start` (init) input and consumes its `halt` flag.
- Handles a go/done/ack handshake with the host or testbench. Holds the core in init for a programmable number of cycles, then releases it.
- Measures run length in cycles and aborts with a timeout flag if `halt` never arrives.
- Also counts completed runs, so back-to-back programs can be sequenced.

Parameters:
- START_CYCLES, 2, number of cycles `start` stays high after `go` is accepted; legal range is 1 or more.
- CW, 16, width of the cycle counter.
- TIMEOUT, 16'hFFFF, number of RUN cycles after which the run aborts; legal range is 1 to 2^CW-1.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- reset_n  input  1  reset, synchronous, active-low.
- go  input  1  host request to begin a run; sampled only in IDLE.
- ack  input  1  host acknowledge of result; sampled only in DONE.
- halt  input  1  done flag from the processor.
- start  output  1  init to the processor, active high.
- busy  output  1  high in START and RUN.
- done  output  1  high in DONE.
- timeout  output  1  high in DONE when the run was aborted.
- cycle_count  output  CW  number of RUN cycles observed with halt=0.
- run_count  output  8  number of completed runs (normal or timeout).

Behaviour:
- All outputs are registered. FSM states: IDLE, START, RUN, DONE.
- Reset: on a posedge with reset_n=0, regardless of state (including mid-run):
  - state=IDLE, start=1, busy=0, done=0, timeout=0, cycle_count=0, run_count=0.
- IDLE:
  - start=1, which parks the core.
  - go=1 → START. Load the start counter with START_CYCLES-1, clear cycle_count and timeout, set busy=1.
  - halt is ignored.
- START:
  - start=1. The start counter decrements each cycle.
  - When the counter reaches 0 → RUN, with start=0 on that same edge.
  - Timing: go sampled at edge n gives start=0 from edge n+START_CYCLES.
  - halt is ignored, since it may be stale from the previous program.
- RUN (start=0, busy=1), evaluated each edge in this priority order:
  - halt=1 → DONE; cycle_count holds, timeout=0.
  - Otherwise, if cycle_count==TIMEOUT-1 → cycle_count=TIMEOUT, timeout=1, DONE.
  - Otherwise cycle_count+1.
  - If halt and the timeout boundary coincide, halt wins and timeout=0.
- Entry to DONE: run_count increments, wrapping 255→0; start=1 (core re-parked); busy=0; done=1.
- DONE:
  - done, timeout and cycle_count hold until ack=1 → IDLE, done=0.
  - timeout and cycle_count are retained in IDLE until the next go is accepted.
- go is ignored outside IDLE, including go and ack in the same cycle in DONE. A new run needs go in a later IDLE cycle.
- ack is ignored outside DONE.
- cycle_count never wraps; it saturates at TIMEOUT by construction.
- No combinational path from any input to any output.

Test Plan:
- Reset behaviour: reset_n=0 for 2 edges during RUN → next cycle state=IDLE, start=1, busy=0, done=0, cycle_count=0, run_count=0.
- Basic run (START_CYCLES=2): go at edge n, halt rises after 5 RUN cycles →
  - start=1 through edge n+1 and 0 from edge n+2;
  - done=1, cycle_count=5, timeout=0, run_count=1;
  - start=1 again on the DONE edge.
- Stale halt: halt held 1 from IDLE through START → no early DONE; RUN's first edge with halt=1 gives done=1, cycle_count=0.
- Timeout (TIMEOUT=10): halt never asserted → 10 edges after RUN entry, cycle_count=10, timeout=1, done=1. In the same setup, halt=1 on the edge where cycle_count=9 gives cycle_count=9, timeout=0.
- Handshake: go pulsed during RUN and DONE is ignored; ack+go together in DONE → IDLE only. A later go starts run 2, clearing cycle_count and timeout. After 256 runs, run_count wraps to 0.
- Reset mid-START: reset_n=0 one cycle after go → IDLE, start=1, busy=0; a subsequent go gives the full START_CYCLES init again.

Source files
------------

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: holds it in init, releases it, times the run
// and reports done/timeout through a go/done/ack handshake with the host.
//
// Handshake: go is accepted only in IDLE; done stays high until ack is seen in DONE;
// go and ack present in any other state are ignored.
module run_sequencer #(
  parameter int unsigned     START_CYCLES = 2,
  parameter int unsigned     CW           = 16,
  parameter logic [CW-1:0]   TIMEOUT      = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          go,
  input  logic          ack,
  input  logic          halt,
  output logic          start,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count,
  output logic [7:0]    run_count,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned   SW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SW-1:0] SCNT_INIT = SW'(START_CYCLES - 1);
  localparam logic [CW-1:0] CC_LAST   = TIMEOUT - CW'(1);

  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic [7:0]    run_count_q, run_count_d;
  logic          enter_done;

  always_comb begin
    state_d       = state_q;
    scnt_d        = scnt_q;
    start_d       = start_q;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    run_count_d   = run_count_q;
    enter_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start_d = 1'b1;
        if (go) begin
          state_d       = ST_START;
          scnt_d        = SCNT_INIT;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          busy_d        = 1'b1;
        end
      end
      ST_START: begin
        // halt may be left over from the previous program, so it is not looked at here
        if (scnt_q == '0) begin
          state_d = ST_RUN;
          start_d = 1'b0;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end
      ST_RUN: begin
        if (halt) begin
          timeout_d  = 1'b0;
          enter_done = 1'b1;
        end else if (cycle_count_q == CC_LAST) begin
          cycle_count_d = TIMEOUT;
          timeout_d     = 1'b1;
          enter_done    = 1'b1;
        end else begin
          cycle_count_d = cycle_count_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_done) begin
      state_d     = ST_DONE;
      run_count_d = run_count_q + 8'd1;
      start_d     = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      scnt_q        <= '0;
      start_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      run_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      run_count_q   <= run_count_d;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign run_count   = run_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios plus random traffic, every output
// compared each cycle against an event-level model of the run sequence.
module tb_run_sequencer;

  localparam int            START_CYCLES = 2;
  localparam int            CW           = 16;
  localparam logic [CW-1:0] TIMEOUT      = 16'd10;

  // clock / reset
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  logic go = 1'b0;
  logic ack = 1'b0;
  logic halt = 1'b0;
  logic          start, busy, done, timeout;
  logic [CW-1:0] cycle_count;
  logic [7:0]    run_count;
  logic [1:0]    dbg_state;

  always #5 CLK = ~CLK;

  run_sequencer #(
    .START_CYCLES(START_CYCLES),
    .CW(CW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .go(go),
    .ack(ack),
    .halt(halt),
    .start(start),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count),
    .run_count(run_count),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // model: a run is "active" from go acceptance until it finishes; m_age counts
  // edges since go, so the core is released once START_CYCLES edges have passed
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_to     = 1'b0;
  int m_age    = 0;
  int m_cc     = 0;
  int m_runs   = 0;

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic finish_run(input bit to);
    m_active = 1'b0;
    m_done   = 1'b1;
    m_to     = to;
    m_runs   = (m_runs + 1) % 256;
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_to     = 1'b0;
      m_age    = 0;
      m_cc     = 0;
      m_runs   = 0;
    end else if (m_active) begin
      if (m_age >= START_CYCLES) begin
        if (halt) finish_run(1'b0);
        else if (m_cc + 1 == int'(TIMEOUT)) begin
          m_cc = int'(TIMEOUT);
          finish_run(1'b1);
        end else m_cc++;
      end
      m_age++;
    end else if (m_done) begin
      if (ack) m_done = 1'b0;
    end else if (go) begin
      m_active = 1'b1;
      m_age    = 0;
      m_cc     = 0;
      m_to     = 1'b0;
    end
  endtask

  // scoreboard: inputs change just after a negedge, so at the next negedge they are
  // exactly what the intervening posedge sampled
  initial begin
    forever begin
      @(negedge CLK);
      model_step();
      check_val("start", start, 32'(!(m_active && m_age >= START_CYCLES)));
      check_val("busy", busy, 32'(m_active));
      check_val("done", done, 32'(m_done));
      check_val("timeout", timeout, 32'(m_to));
      check_val("cycle_count", cycle_count, 32'(m_cc));
      check_val("run_count", run_count, 32'(m_runs));
    end
  end

  // driver: apply inputs for one posedge, return just after the following negedge
  task automatic cyc(input bit g, input bit a, input bit h, input bit rn = 1'b1);
    go = g;
    ack = a;
    halt = h;
    reset_n = rn;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    // reset state
    repeat (3) cyc(0, 0, 0, 0);
    check_val("lit_rst_start", start, 1);
    check_val("lit_rst_busy", busy, 0);
    check_val("lit_rst_runs", run_count, 0);

    // basic run: start high for two edges after go, five halt-free RUN edges
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check_val("lit_basic_start_n", start, 1);
    check_val("lit_basic_busy", busy, 1);
    cyc(0, 0, 0);
    check_val("lit_basic_start_n1", start, 1);
    cyc(0, 0, 0);
    check_val("lit_basic_start_n2", start, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check_val("lit_basic_done", done, 1);
    check_val("lit_basic_cc", cycle_count, 5);
    check_val("lit_basic_to", timeout, 0);
    check_val("lit_basic_runs", run_count, 1);
    check_val("lit_basic_restart", start, 1);
    cyc(0, 1, 0);

    // stale halt held through IDLE and START
    cyc(0, 0, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check_val("lit_stale_no_done", done, 0);
    cyc(0, 0, 1);
    check_val("lit_stale_done", done, 1);
    check_val("lit_stale_cc", cycle_count, 0);
    cyc(0, 1, 0);

    // timeout, then go in DONE and go+ack together
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    repeat (9) cyc(0, 0, 0);
    check_val("lit_to_cc9", cycle_count, 9);
    check_val("lit_to_not_done", done, 0);
    cyc(0, 0, 0);
    check_val("lit_to_cc", cycle_count, 10);
    check_val("lit_to_flag", timeout, 1);
    check_val("lit_to_done", done, 1);
    cyc(1, 0, 0);
    check_val("lit_go_in_done", done, 1);
    cyc(1, 1, 0);
    check_val("lit_goack_busy", busy, 0);
    check_val("lit_goack_done", done, 0);
    check_val("lit_idle_keeps_to", timeout, 1);
    check_val("lit_idle_keeps_cc", cycle_count, 10);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check_val("lit_go_clears_cc", cycle_count, 0);
    check_val("lit_go_clears_to", timeout, 0);

    // halt on the timeout boundary wins; go mid-run ignored
    repeat (2) cyc(0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(i == 4, 0, 0);
    cyc(0, 0, 1);
    check_val("lit_bound_cc", cycle_count, 9);
    check_val("lit_bound_to", timeout, 0);
    check_val("lit_bound_runs", run_count, 4);
    cyc(0, 1, 0);

    // reset mid-RUN for two edges
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    check_val("lit_midrun_start", start, 1);
    check_val("lit_midrun_cc", cycle_count, 0);
    check_val("lit_midrun_runs", run_count, 0);

    // reset mid-START, then a full init again
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0, 0);
    check_val("lit_midstart_busy", busy, 0);
    check_val("lit_midstart_start", start, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check_val("lit_reinit_n1", start, 1);
    cyc(0, 0, 0);
    check_val("lit_reinit_n2", start, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);

    // run_count wrap after 256 runs from reset
    cyc(0, 0, 0, 0);
    for (int r = 0; r < 256; r++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      if (r == 254) check_val("lit_runs_255", run_count, 255);
      cyc(0, 1, 0);
    end
    check_val("lit_runs_wrap", run_count, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 59) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
